// File: rtl/oled_seq_player.sv
// oled_seq_player: SSD1306 power-up / power-down sequencer driving
// the rail, reset and DC pins and feeding command bytes to SpiCtrl_OLED.
module oled_seq_player #(
  parameter int unsigned CLK_HZ          = 12000000,
  parameter int unsigned STEP_DELAY_MS   = 1,
  parameter int unsigned VBAT_DELAY_MS   = 100,
  parameter int unsigned PWROFF_DELAY_MS = 100,
  parameter logic [7:0]  CONTRAST        = 8'h0F,
  parameter bit          SEG_REMAP       = 1'b1,
  parameter bit          COM_SCAN_REV    = 1'b1,
  parameter logic [7:0]  COM_CFG         = 8'h20
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       MODE,
  output logic       BUSY,
  output logic       DONE,
  output logic       SPI_EN,
  output logic [7:0] SPI_DATA,
  input  logic       SPI_FIN,
  output logic       DC,
  output logic       RES,
  output logic       VBAT,
  output logic       VDD,
  output logic [4:0] STEP
);

  localparam int unsigned MS = CLK_HZ / 1000;
  localparam int CW = $clog2(4095 * MS + 1);

  localparam logic [11:0] D_STEP = 12'(STEP_DELAY_MS);
  localparam logic [11:0] D_VBAT = 12'(VBAT_DELAY_MS);
  localparam logic [11:0] D_OFF  = 12'(PWROFF_DELAY_MS);
  localparam logic [7:0]  SEG_B  = SEG_REMAP ? 8'hA1 : 8'hA0;
  localparam logic [7:0]  COM_B  = COM_SCAN_REV ? 8'hC8 : 8'hC0;

  if (CLK_HZ < 1000 || CLK_HZ % 1000 != 0) begin : g_bad_clk
    $error("oled_seq_player: CLK_HZ must be a multiple of 1000");
  end
  if (STEP_DELAY_MS == 0 || STEP_DELAY_MS > 4095 ||
      VBAT_DELAY_MS == 0 || VBAT_DELAY_MS > 4095 ||
      PWROFF_DELAY_MS == 0 || PWROFF_DELAY_MS > 4095) begin : g_bad_dly
    $error("oled_seq_player: delay parameters must be 1..4095");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PIN, S_SPI_REQ,
    S_SPI_WAIT, S_SPI_CLR, S_DLY, S_FIN
  } state_t;

  typedef enum logic [1:0] {K_PIN, K_SPI, K_DLY, K_END} kind_t;
  typedef enum logic [1:0] {P_VDD, P_VBAT, P_RES} pin_t;

  state_t         state, state_nx;
  kind_t          kind;
  pin_t           pin_sel;
  logic           pin_val;
  logic [7:0]     cmd;
  logic [11:0]    dly_ms;
  logic           mode_q;
  logic           booted;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  dly_load;

  assign DC       = 1'b0;
  assign dly_load = CW'(dly_ms) * CW'(MS) - CW'(1);

  // Step table: one entry per STEP for the latched mode
  always_comb begin
    kind    = K_END;
    pin_sel = P_VDD;
    pin_val = 1'b1;
    cmd     = 8'h00;
    dly_ms  = D_STEP;
    if (!mode_q) begin
      case (STEP)
        5'd0:  begin kind = K_PIN; pin_sel = P_VDD; pin_val = 1'b0; end
        5'd1:  kind = K_DLY;
        5'd2:  begin kind = K_SPI; cmd = 8'hAE; end
        5'd3:  begin kind = K_PIN; pin_sel = P_RES; pin_val = 1'b0; end
        5'd4:  kind = K_DLY;
        5'd5:  begin kind = K_PIN; pin_sel = P_RES; pin_val = 1'b1; end
        5'd6:  kind = K_DLY;
        5'd7:  begin kind = K_SPI; cmd = 8'h8D; end
        5'd8:  begin kind = K_SPI; cmd = 8'h14; end
        5'd9:  begin kind = K_SPI; cmd = 8'hD9; end
        5'd10: begin kind = K_SPI; cmd = 8'hF1; end
        5'd11: begin kind = K_PIN; pin_sel = P_VBAT; pin_val = 1'b0; end
        5'd12: begin kind = K_DLY; dly_ms = D_VBAT; end
        5'd13: begin kind = K_SPI; cmd = 8'h81; end
        5'd14: begin kind = K_SPI; cmd = CONTRAST; end
        5'd15: begin kind = K_SPI; cmd = SEG_B; end
        5'd16: begin kind = K_SPI; cmd = COM_B; end
        5'd17: begin kind = K_SPI; cmd = 8'hDA; end
        5'd18: begin kind = K_SPI; cmd = COM_CFG; end
        5'd19: begin kind = K_SPI; cmd = 8'hAF; end
        default: kind = K_END;
      endcase
    end else begin
      case (STEP)
        5'd0:  begin kind = K_SPI; cmd = 8'hAE; end
        5'd1:  begin kind = K_PIN; pin_sel = P_VBAT; pin_val = 1'b1; end
        5'd2:  begin kind = K_DLY; dly_ms = D_OFF; end
        5'd3:  begin kind = K_PIN; pin_sel = P_VDD; pin_val = 1'b1; end
        default: kind = K_END;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:     if (START) state_nx = S_FETCH;
      S_FETCH: begin
        unique case (kind)
          K_PIN: state_nx = S_PIN;
          K_SPI: state_nx = S_SPI_REQ;
          K_DLY: state_nx = S_DLY;
          K_END: state_nx = S_FIN;
        endcase
      end
      S_PIN:      state_nx = S_FETCH;
      S_SPI_REQ:  if (!SPI_FIN) state_nx = S_SPI_WAIT;
      S_SPI_WAIT: if (SPI_FIN) state_nx = S_SPI_CLR;
      S_SPI_CLR:  if (!SPI_FIN) state_nx = S_FETCH;
      S_DLY:      if (cnt == '0) state_nx = S_FETCH;
      S_FIN:      state_nx = S_IDLE;
    endcase
  end

  // RES leaves reset low and releases on the first edge after RST_N rises
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q   <= 1'b0;
      booted   <= 1'b0;
      cnt      <= '0;
      STEP     <= 5'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      SPI_EN   <= 1'b0;
      SPI_DATA <= 8'h00;
      RES      <= 1'b0;
      VBAT     <= 1'b1;
      VDD      <= 1'b1;
    end else begin
      booted <= 1'b1;
      if (!booted) RES <= 1'b1;
      case (state)
        S_IDLE: begin
          if (START) begin
            mode_q <= MODE;
            DONE   <= 1'b0;
            BUSY   <= 1'b1;
            STEP   <= 5'd0;
          end
        end
        S_FETCH: if (kind == K_DLY) cnt <= dly_load;
        S_PIN: begin
          STEP <= STEP + 5'd1;
          case (pin_sel)
            P_VDD:   VDD  <= pin_val;
            P_VBAT:  VBAT <= pin_val;
            default: RES  <= pin_val;
          endcase
        end
        S_SPI_REQ: begin
          if (!SPI_FIN) begin
            SPI_DATA <= cmd;
            SPI_EN   <= 1'b1;
          end
        end
        S_SPI_WAIT: if (SPI_FIN) SPI_EN <= 1'b0;
        S_SPI_CLR:  if (!SPI_FIN) STEP <= STEP + 5'd1;
        S_DLY: begin
          if (cnt == '0) STEP <= STEP + 5'd1;
          else           cnt  <= cnt - CW'(1);
        end
        S_FIN: begin
          DONE <= 1'b1;
          BUSY <= 1'b0;
          STEP <= 5'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_seq_player.sv
// tb_oled_seq_player: scoreboard bench for the OLED power sequencer
// with a randomised SPI responder and a table-level reference model.
`timescale 1ns/1ps
module tb_oled_seq_player;

  localparam int HZ = 4000;
  localparam int MS = HZ / 1000;
  localparam int SD = 1;
  localparam int VD = 100;
  localparam int PD = 100;
  // FETCH before the delay, FETCH after it, then the PIN or SPI_REQ cycle
  localparam int OVH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, mode = 1'b0, spi_fin = 1'b0;
  logic busy, done, spi_en, dc, res, vbat, vdd;
  logic [7:0] spi_data;
  logic [4:0] step;

  logic start2 = 1'b0, mode2 = 1'b0, spi_fin2 = 1'b0;
  logic busy2, done2, spi_en2, dc2, res2, vbat2, vdd2;
  logic [7:0] spi_data2;
  logic [4:0] step2;

  always #5 clk = ~clk;

  oled_seq_player #(.CLK_HZ(HZ)) u_dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode),
    .BUSY(busy), .DONE(done), .SPI_EN(spi_en), .SPI_DATA(spi_data),
    .SPI_FIN(spi_fin), .DC(dc), .RES(res), .VBAT(vbat), .VDD(vdd),
    .STEP(step)
  );

  oled_seq_player #(
    .CLK_HZ(HZ), .STEP_DELAY_MS(2), .VBAT_DELAY_MS(3),
    .PWROFF_DELAY_MS(2), .CONTRAST(8'h7F), .SEG_REMAP(1'b0),
    .COM_SCAN_REV(1'b0), .COM_CFG(8'h02)
  ) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start2), .MODE(mode2),
    .BUSY(busy2), .DONE(done2), .SPI_EN(spi_en2), .SPI_DATA(spi_data2),
    .SPI_FIN(spi_fin2), .DC(dc2), .RES(res2), .VBAT(vbat2), .VDD(vdd2),
    .STEP(step2)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pu_byte(input int i, input logic [7:0] c,
                                         input bit seg, input bit com,
                                         input logic [7:0] cfg);
    logic [7:0] t [12];
    t = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, c,
          seg ? 8'hA1 : 8'hA0, com ? 8'hC8 : 8'hC0, 8'hDA, cfg, 8'hAF};
    return t[i];
  endfunction

  // Expected byte, rail/reset pins while it is sent, and cycles since
  // the last pin edge when a delay precedes it (-1 = not checked)
  typedef struct {
    logic [7:0] data;
    logic [2:0] pins;
    int         gap;
  } exp_t;

  exp_t sbq[$];
  logic mv = 1'b1, mb = 1'b1, mr = 1'b1;

  task automatic push(input logic [7:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.pins = {mv, mb, mr};
    e.gap  = gap;
    sbq.push_back(e);
  endtask

  task automatic model_run(input logic m);
    if (!m) begin
      mv = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (i == 1) mr = 1'b1;
        if (i == 5) mb = 1'b0;
        push(pu_byte(i, 8'h0F, 1'b1, 1'b1, 8'h20),
             i == 0 ? SD * MS + OVH : (i == 5 ? VD * MS + OVH : -1));
      end
    end else begin
      push(8'hAE, -1);
      mb = 1'b1;
      mv = 1'b1;
    end
  endtask

  int fin_lat = 3;
  int fin_hold = 1;

  initial begin : spi_model
    int ec, hc;
    ec = 0;
    hc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (spi_en) begin
        hc = 0;
        ec++;
        if (ec >= fin_lat) spi_fin = 1'b1;
      end else begin
        ec = 0;
        if (spi_fin) begin
          hc++;
          if (hc >= fin_hold) spi_fin = 1'b0;
        end
      end
    end
  end

  initial begin : spi_model2
    forever begin
      @(posedge clk);
      #1;
      spi_fin2 = spi_en2;
    end
  end

  int cyc = 0, t_pin = 0;
  int t_res_fall = 0, t_res_rise = 0, t_vbat_rise = 0, t_vdd_rise = 0;
  logic [7:0] got2[$];

  initial begin : monitor
    exp_t e;
    logic en_q, fin_q, vdd_q, vbat_q, res_q, en2_q;
    en_q = 1'b0; fin_q = 1'b0; en2_q = 1'b0;
    vdd_q = 1'b1; vbat_q = 1'b1; res_q = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (spi_en === 1'b1 && !en_q) begin
        check("fin_low_at_en", int'(fin_q), 0);
        if (sbq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL extra_byte: got %0h, required none", spi_data);
        end else begin
          e = sbq.pop_front();
          check("byte", int'(spi_data), int'(e.data));
          check("pins_at_byte", int'({vdd, vbat, res}), int'(e.pins));
          if (e.gap >= 0) check("dly_gap", cyc - t_pin, e.gap);
        end
      end
      if ({vdd, vbat, res} !== {vdd_q, vbat_q, res_q}) t_pin = cyc;
      if (!res && res_q) t_res_fall = cyc;
      if (res && !res_q) t_res_rise = cyc;
      if (vbat && !vbat_q) t_vbat_rise = cyc;
      if (vdd && !vdd_q) t_vdd_rise = cyc;
      if (spi_en2 === 1'b1 && !en2_q) got2.push_back(spi_data2);
      en_q = spi_en; fin_q = spi_fin; en2_q = spi_en2;
      vdd_q = vdd; vbat_q = vbat; res_q = res;
    end
  end

  task automatic run_seq(input logic m, input string tag);
    int n;
    n = 0;
    model_run(m);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, int'(busy), 1);
    check({tag, "_done_clr"}, int'(done), 0);
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      start = ($urandom_range(0, 5) == 0);
      mode = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_idle"}, int'({busy, step}), 0);
    check({tag, "_pins"}, int'({vdd, vbat, res, dc}), int'({mv, mb, mr, 1'b0}));
    check({tag, "_left"}, sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic idle_hold(input string tag);
    repeat ($urandom_range(1, 40)) @(negedge clk);
    check({tag, "_done_hold"}, int'(done), 1);
  endtask

  initial begin : stim
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pins", int'({busy, done, spi_en, dc, res, vbat, vdd}), 7'b0000011);
    check("rst_data", int'({step, spi_data}), 0);
    #2 rst_n = 1'b1;
    #1 check("res_before_edge", int'(res), 0);
    @(posedge clk);
    #1 check("res_after_edge", int'(res), 1);

    for (int it = 0; it < 3; it++) begin
      fin_lat  = (it == 0) ? 3 : int'($urandom_range(1, 5));
      fin_hold = (it == 1) ? 20 : int'($urandom_range(1, 3));
      run_seq(1'b0, "pu");
      check("res_low", t_res_rise - t_res_fall, SD * MS + OVH);
      idle_hold("pu");
      run_seq(1'b1, "pd");
      check("vdd_off_gap", t_vdd_rise - t_vbat_rise, PD * MS + OVH);
      idle_hold("pd");
    end

    fin_lat = 3;
    fin_hold = 1;
    model_run(1'b0);
    @(negedge clk);
    start = 1'b1;
    mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vbat && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_vbat_on", int'(vbat), 0);
    repeat (50) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check("abort_pins", int'({spi_en, vbat, vdd, busy}), 4'b0110);
    sbq.delete();
    mv = 1'b1;
    mb = 1'b1;
    mr = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_seq(1'b0, "rerun");
    check("rerun_res_low", t_res_rise - t_res_fall, SD * MS + OVH);
    run_seq(1'b1, "rerun_pd");

    got2.delete();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("d2_done", int'(done2), 1);
    check("d2_count", got2.size(), 12);
    for (int i = 0; i < 12 && i < got2.size(); i++)
      check("d2_byte", int'(got2[i]),
            int'(pu_byte(i, 8'h7F, 1'b0, 1'b0, 8'h02)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
